vga_sprite_compositor: RTL and testbench

Parametrised successor to the single-raccoon VGA display. It generates VGA timing from configurable porch and sync widths and composites up to NUM_SPRITES solid-colour rectangular sprites over a programmable background. Each sprite has a fixed priority. Sprite attributes are double-buffered and take effect only at frame boundaries, so the picture never tears. The block sits between the game-logic blocks, which drive positions and colours, and the board VGA pins.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing.sv | 64 ++++++
 rtl/vga_sprite_compositor.sv | 142 ++++++++++++++
 tb/tb_vga_sprite_compositor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the display blocks.
// Defaults describe standard 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

    localparam int CNT_W = 10;
    localparam int RGB_W = 9;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    typedef logic [RGB_W-1:0] rgb_t;

    function automatic int seg_total(input int sync, input int back, input int active, input int front);
        return sync + back + active + front;
    endfunction

    localparam int H_TOTAL = seg_total(DEF_H_SYNC, DEF_H_BACK, DEF_H_ACTIVE, DEF_H_FRONT);
    localparam int V_TOTAL = seg_total(DEF_V_SYNC, DEF_V_BACK, DEF_V_ACTIVE, DEF_V_FRONT);

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA raster counters; segment order from 0 is sync, back porch, active, front porch.
// Status outputs are decoded straight from the counter registers.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             active,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             frame_end
);

    localparam int H_TOT = seg_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
    localparam int V_TOT = seg_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
    localparam int CW1   = CNT_W + 1;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
    // Region bounds kept one bit wider so an end of exactly 1024 does not wrap.
    localparam logic [CNT_W:0] H_S  = CW1'(H_SYNC);
    localparam logic [CNT_W:0] H_A0 = CW1'(H_SYNC + H_BACK);
    localparam logic [CNT_W:0] H_A1 = CW1'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W:0] V_S  = CW1'(V_SYNC);
    localparam logic [CNT_W:0] V_A0 = CW1'(V_SYNC + V_BACK);
    localparam logic [CNT_W:0] V_A1 = CW1'(V_SYNC + V_BACK + V_ACTIVE);

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
        $error("vga_timing: H_TOTAL/V_TOTAL must not exceed 1024");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end else begin
            h_count <= h_count + 1'b1;
        end
    end

    logic [CNT_W:0] h_w, v_w;
    assign h_w = {1'b0, h_count};
    assign v_w = {1'b0, v_count};

    assign hs_raw    = h_w < H_S;
    assign vs_raw    = v_w < V_S;
    assign active    = (h_w >= H_A0) && (h_w < H_A1) && (v_w >= V_A0) && (v_w < V_A1);
    assign frame_end = (h_count == H_LAST) && (v_count == V_LAST);

endmodule

// File: rtl/vga_sprite_compositor.sv
// VGA timing plus fixed-priority compositing of solid rectangular sprites over a background.
// Sprite/background inputs are shadowed once per frame so a frame never mixes old and new state.
module vga_sprite_compositor
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int SYNC_NEG    = 1,
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [10*NUM_SPRITES-1:0]      sprite_x,
    input  logic [10*NUM_SPRITES-1:0]      sprite_y,
    input  logic [RGB_W*NUM_SPRITES-1:0]   sprite_rgb,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    input  logic [RGB_W-1:0]               bg_rgb,
    output logic [2:0]                     vga_r,
    output logic [2:0]                     vga_g,
    output logic [2:0]                     vga_b,
    output logic                           vga_hs,
    output logic                           vga_vs,
    output logic                           frame_start
);

    localparam int H_TOT = seg_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
    localparam int V_TOT = seg_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
    localparam logic [CNT_W-1:0] H_PRE  = CNT_W'(H_TOT - 2);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
    localparam logic SYNC_OFF = (SYNC_NEG != 0);

    if (NUM_SPRITES < 1 || NUM_SPRITES > 8) begin : g_bad_count
        $error("vga_sprite_compositor: NUM_SPRITES must be 1..8");
    end

    logic [CNT_W-1:0] h_count, v_count;
    logic             active, hs_raw, vs_raw, frame_end;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .h_count  (h_count),
        .v_count  (v_count),
        .active   (active),
        .hs_raw   (hs_raw),
        .vs_raw   (vs_raw),
        .frame_end(frame_end)
    );

    logic [NUM_SPRITES-1:0][9:0] sh_x, sh_y;
    rgb_t [NUM_SPRITES-1:0]      sh_rgb;
    logic [NUM_SPRITES-1:0]      sh_en;
    rgb_t                        sh_bg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x   <= '0;
            sh_y   <= '0;
            sh_rgb <= '0;
            sh_en  <= '0;
            sh_bg  <= '0;
        end else if (frame_end) begin
            sh_x   <= sprite_x;
            sh_y   <= sprite_y;
            sh_rgb <= sprite_rgb;
            sh_en  <= sprite_en;
            sh_bg  <= bg_rgb;
        end
    end

    // High in exactly the cycle the counters read the last pixel of the frame.
    always_ff @(posedge clk) begin
        if (rst) frame_start <= 1'b0;
        else     frame_start <= (h_count == H_PRE) && (v_count == V_LAST);
    end

    // Outside the active window px/py wrap to large values; active gates those later.
    logic [10:0] px, py;
    assign px = {1'b0, h_count} - 11'(H_SYNC + H_BACK);
    assign py = {1'b0, v_count} - 11'(V_SYNC + V_BACK);

    logic [NUM_SPRITES-1:0] hit;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
        logic [10:0] x0, y0;
        assign x0 = {1'b0, sh_x[i]};
        assign y0 = {1'b0, sh_y[i]};
        assign hit[i] = sh_en[i] && (px >= x0) && (px < x0 + 11'(SPRITE_W))
                                 && (py >= y0) && (py < y0 + 11'(SPRITE_H));
    end

    logic                   act_s1, hs_s1, vs_s1;
    logic [NUM_SPRITES-1:0] hit_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_s1 <= 1'b0;
            hs_s1  <= SYNC_OFF;
            vs_s1  <= SYNC_OFF;
            hit_s1 <= '0;
        end else begin
            act_s1 <= active;
            hs_s1  <= hs_raw ^ SYNC_OFF;
            vs_s1  <= vs_raw ^ SYNC_OFF;
            hit_s1 <= hit;
        end
    end

    rgb_t pix;

    always_comb begin
        pix = sh_bg;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_s1[i]) pix = sh_rgb[i];
        end
        if (!act_s1) pix = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {vga_r, vga_g, vga_b} <= '0;
            vga_hs                <= SYNC_OFF;
            vga_vs                <= SYNC_OFF;
        end else begin
            {vga_r, vga_g, vga_b} <= pix;
            vga_hs                <= hs_s1;
            vga_vs                <= vs_s1;
        end
    end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor on a shrunken raster (23x17 clocks per frame).
// cyc counts clocks since the last reset edge, so counter value k shows on the pins at cyc == k+2.
module tb_vga_sprite_compositor;

    localparam int HA = 16, HF = 2, HS = 3, HB = 2;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FR = HT * VT;
    localparam int HO = HS + HB;
    localparam int VO = VS + VB;
    localparam int N  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [10*N-1:0]  sprite_x, sprite_y;
    logic [9*N-1:0]   sprite_rgb;
    logic [N-1:0]     sprite_en;
    logic [8:0]       bg_rgb;
    logic [2:0]       vga_r, vga_g, vga_b;
    logic             vga_hs, vga_vs, frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    vga_sprite_compositor #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_NEG(1), .NUM_SPRITES(N), .SPRITE_W(4), .SPRITE_H(3)
    ) dut (
        .clk(clk), .rst(rst),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_rgb(sprite_rgb),
        .sprite_en(sprite_en), .bg_rgb(bg_rgb),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic wait_to(input int t);
        int guard = 0;
        while (cyc < t && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_to", cyc, t);
    endtask

    task automatic set_sprite(input int i, input int x, input int y, input logic [8:0] c, input logic en);
        sprite_x[10*i +: 10]  = 10'(x);
        sprite_y[10*i +: 10]  = 10'(y);
        sprite_rgb[9*i +: 9]  = c;
        sprite_en[i]          = en;
    endtask

    task automatic set_cfg(input int g);
        for (int i = 0; i < N; i++) set_sprite(i, 0, 0, 9'h000, 1'b0);
        case (g)
            2: begin
                set_sprite(0, 6, 6, 9'h038, 1'b1);
                set_sprite(1, 0, 0, 9'h155, 1'b0);
                set_sprite(2, 8, 7, 9'h1FF, 1'b1);
                set_sprite(3, 10, 8, 9'h0AA, 1'b1);
                bg_rgb = 9'h049;
            end
            3: begin
                set_sprite(1, 14, 10, 9'h0E0, 1'b1);
                bg_rgb = 9'h1B6;
            end
            default: begin
                set_sprite(0, 2, 1, 9'h1C0, 1'b1);
                bg_rgb = 9'h007;
            end
        endcase
    endtask

    task automatic chk_px(input int f, input int h, input int v, input logic [8:0] c,
                          input logic hs, input logic vs, input string tag);
        wait_to(f * FR + v * HT + h + 2);
        check($sformatf("%s.rgb", tag), {vga_r, vga_g, vga_b}, c);
        check($sformatf("%s.hs", tag), vga_hs, hs);
        check($sformatf("%s.vs", tag), vga_vs, vs);
    endtask

    // Continuous sync/blanking/frame_start check against the raster position.
    always @(negedge clk) begin : mon
        int k, hh, vv;
        logic ehs, evs, blank;
        if (mon_en && !rst) begin
            if (cyc < 2) begin
                ehs = 1'b1; evs = 1'b1; blank = 1'b1;
            end else begin
                k  = cyc - 2;
                hh = k % HT;
                vv = (k / HT) % VT;
                ehs = hh >= HS;
                evs = vv >= VS;
                blank = !(hh >= HO && hh < HO + HA && vv >= VO && vv < VO + VA);
            end
            check("mon.hs", vga_hs, ehs);
            check("mon.vs", vga_vs, evs);
            check("mon.fs", frame_start, (cyc % FR) == FR - 1);
            if (blank) check("mon.blank", {vga_r, vga_g, vga_b}, 9'h000);
        end
    end

    typedef struct {
        int         f;
        int         h;
        int         v;
        logic [8:0] rgb;
        logic       hs;
        logic       vs;
    } vec_t;

    vec_t vecs[$];
    int   cfg_done;

    initial begin
        sprite_x = '0; sprite_y = '0; sprite_rgb = '0; sprite_en = '0; bg_rgb = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.rgb", {vga_r, vga_g, vga_b}, 9'h000);
        check("rst.hs", vga_hs, 1'b1);
        check("rst.vs", vga_vs, 1'b1);
        check("rst.fs", frame_start, 1'b0);
        rst = 1'b0;
        mon_en = 1'b1;

        // frame 0: shadows still clear although inputs already hold a sprite
        vecs.push_back('{0, HO+2,  VO+1,  9'h000, 1'b1, 1'b1});
        vecs.push_back('{0, HO+10, VO+5,  9'h000, 1'b1, 1'b1});
        // frame 1: sprite 0 at (2,1) red over blue
        vecs.push_back('{1, 10,    0,     9'h000, 1'b1, 1'b0});
        vecs.push_back('{1, 0,     VO+1,  9'h000, 1'b0, 1'b1});
        vecs.push_back('{1, HO-1,  VO+1,  9'h000, 1'b1, 1'b1});
        vecs.push_back('{1, HO+1,  VO+1,  9'h007, 1'b1, 1'b1});
        vecs.push_back('{1, HO+2,  VO+1,  9'h1C0, 1'b1, 1'b1});
        vecs.push_back('{1, HO+6,  VO+1,  9'h007, 1'b1, 1'b1});
        vecs.push_back('{1, HO+5,  VO+3,  9'h1C0, 1'b1, 1'b1});
        vecs.push_back('{1, HO+2,  VO+4,  9'h007, 1'b1, 1'b1});
        // frame 2: overlapping sprites, lowest index wins
        vecs.push_back('{2, HO+0,  VO+0,  9'h049, 1'b1, 1'b1});
        vecs.push_back('{2, HO+7,  VO+6,  9'h038, 1'b1, 1'b1});
        vecs.push_back('{2, HO+8,  VO+7,  9'h038, 1'b1, 1'b1});
        vecs.push_back('{2, HO+10, VO+7,  9'h1FF, 1'b1, 1'b1});
        vecs.push_back('{2, HO+12, VO+7,  9'h049, 1'b1, 1'b1});
        vecs.push_back('{2, HO+9,  VO+8,  9'h038, 1'b1, 1'b1});
        vecs.push_back('{2, HO+10, VO+8,  9'h1FF, 1'b1, 1'b1});
        vecs.push_back('{2, HO+8,  VO+9,  9'h1FF, 1'b1, 1'b1});
        vecs.push_back('{2, HO+13, VO+9,  9'h0AA, 1'b1, 1'b1});
        // frame 3: sprite 1 clipped at right and bottom edges
        vecs.push_back('{3, HO+13, VO+10, 9'h1B6, 1'b1, 1'b1});
        vecs.push_back('{3, HO+14, VO+10, 9'h0E0, 1'b1, 1'b1});
        vecs.push_back('{3, HO+16, VO+10, 9'h000, 1'b1, 1'b1});
        vecs.push_back('{3, HO+0,  VO+11, 9'h1B6, 1'b1, 1'b1});
        vecs.push_back('{3, HO+15, VO+11, 9'h0E0, 1'b1, 1'b1});
        vecs.push_back('{3, HO+14, VO+12, 9'h000, 1'b1, 1'b1});

        cfg_done = 0;
        foreach (vecs[i]) begin
            for (int g = cfg_done + 1; g <= vecs[i].f + 1; g++) begin
                wait_to((g - 1) * FR + 1);
                set_cfg(g);
                cfg_done = g;
            end
            chk_px(vecs[i].f, vecs[i].h, vecs[i].v, vecs[i].rgb, vecs[i].hs, vecs[i].vs,
                   $sformatf("vec%0d", i));
        end

        // latency: red lands exactly two clocks after the counters reach the sprite origin
        wait_to(4 * FR + (VO + 1) * HT + HO + 2 + 1);
        check("lat.pre", {vga_r, vga_g, vga_b}, 9'h007);
        wait_to(4 * FR + (VO + 1) * HT + HO + 2 + 2);
        check("lat.hit", {vga_r, vga_g, vga_b}, 9'h1C0);

        // mid-frame move is deferred to the next frame
        wait_to(4 * FR + (VO + 2) * HT);
        sprite_x[9:0] = 10'd9;
        chk_px(4, HO+2, VO+3, 9'h1C0, 1'b1, 1'b1, "mid.old");
        chk_px(4, HO+9, VO+3, 9'h007, 1'b1, 1'b1, "mid.oldbg");
        chk_px(5, HO+2, VO+1, 9'h007, 1'b1, 1'b1, "mid.newbg");
        chk_px(5, HO+9, VO+1, 9'h1C0, 1'b1, 1'b1, "mid.new");

        // one-cycle reset mid-line
        wait_to(5 * FR + (VO + 2) * HT + HO + 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2.rgb", {vga_r, vga_g, vga_b}, 9'h000);
        check("rst2.hs", vga_hs, 1'b1);
        check("rst2.vs", vga_vs, 1'b1);
        check("rst2.fs", frame_start, 1'b0);
        chk_px(0, HO+9, VO+1, 9'h000, 1'b1, 1'b1, "rst2.f0");
        chk_px(1, HO+2, VO+1, 9'h007, 1'b1, 1'b1, "rst2.f1bg");
        chk_px(1, HO+9, VO+1, 9'h1C0, 1'b1, 1'b1, "rst2.f1spr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
